// File: rtl/uart_pkg.sv
// Shared UART receive definitions: default frame width, parity selectors and
// the receiver control FSM state encoding.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10,
    ST_STOP   = 2'b11
  } rx_state_e;

  // Map the FSM strobes onto the phase they encode; checkstop > load > shift.
  function automatic rx_state_e strobe_phase(input logic shift,
                                             input logic load,
                                             input logic checkstop);
    if (checkstop) return ST_STOP;
    if (load)      return ST_PARITY;
    if (shift)     return ST_DATA;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out data register with saturating bit counter and
// running parity accumulator for the UART receiver.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] shreg,
  output logic                  parity_acc,
  output logic                  full_c
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  acc_q, acc_d;

  assign full_c     = (bit_cnt_q == CNT_W'(DATA_WIDTH));
  assign shreg      = shreg_q;
  assign parity_acc = acc_q;

  // LSB-first capture: new bit enters at the MSB and walks down.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    if (clear) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
      acc_d     = 1'b0;
    end else if (shift_en && !full_c) begin
      shreg_d   = {rx_in, shreg_q[DATA_WIDTH-1:1]};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      acc_d     = acc_q ^ rx_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      acc_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/uart_rx_shift_unit.sv
// UART receive datapath: captures data/parity/stop bits on FSM strobes and
// presents completed frames to the host with a valid/read handshake.
module uart_rx_shift_unit #(
  parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF,
  parameter bit          PARITY_ODD = uart_pkg::PARITY_EVEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  shift,
  input  logic                  load,
  input  logic                  checkstop,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  paritybiterror,
  output logic                  framing_error,
  output logic                  overrun_error
);

  uart_pkg::rx_state_e phase_c;

  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_acc;
  logic                  full_c;
  logic                  load_rise_c, stop_rise_c;

  logic                  in_parity_q, in_parity_d;
  logic                  in_stop_q, in_stop_d;
  logic                  short_frame_q, short_frame_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  framing_err_q, framing_err_d;
  logic                  overrun_q, overrun_d;

  assign phase_c     = uart_pkg::strobe_phase(shift, load, checkstop);
  assign load_rise_c = (phase_c == uart_pkg::ST_PARITY) && !in_parity_q;
  assign stop_rise_c = (phase_c == uart_pkg::ST_STOP) && !in_stop_q;

  uart_rx_sipo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sipo (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (phase_c == uart_pkg::ST_IDLE),
    .shift_en   (phase_c == uart_pkg::ST_DATA),
    .rx_in      (rx_in),
    .shreg      (shreg),
    .parity_acc (parity_acc),
    .full_c     (full_c)
  );

  // Completion wins over a same-cycle read: valid stays set, overrun is not raised.
  always_comb begin
    in_parity_d   = (phase_c == uart_pkg::ST_PARITY);
    in_stop_d     = (phase_c == uart_pkg::ST_STOP);
    short_frame_d = short_frame_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overrun_d     = overrun_q;

    if (load_rise_c) begin
      parity_err_d  = parity_acc ^ rx_in ^ PARITY_ODD;
      short_frame_d = !full_c;
    end

    if (rd_en && data_valid_q) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    if (stop_rise_c) begin
      data_out_d    = shreg;
      framing_err_d = !rx_in || short_frame_q;
      data_valid_d  = 1'b1;
      short_frame_d = 1'b0;
      if (data_valid_q && !rd_en) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_parity_q   <= 1'b0;
      in_stop_q     <= 1'b0;
      short_frame_q <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      in_parity_q   <= in_parity_d;
      in_stop_q     <= in_stop_d;
      short_frame_q <= short_frame_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign paritybiterror = parity_err_q;
  assign framing_error  = framing_err_q;
  assign overrun_error  = overrun_q;

  // The FSM must never raise more than one phase strobe at a time.
  strobe_onehot_a: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({shift, load, checkstop}))
    else $error("uart_rx_shift_unit: conflicting shift/load/checkstop strobes");

endmodule
